axi_stream_pkt_arbiter: RTL and testbench

//  Packet-granular round-robin merger of NUM_IN length-prepended 64-bit AXI-Stream channels into one stream.

---
 rtl/axi_stream_pkt_arbiter.sv | 120 ++++++++++++
 tb/tb_axi_stream_pkt_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_pkt_arbiter.sv
// axi_stream_pkt_arbiter: packet-granular round-robin merge of NUM_IN AXI-Stream inputs into one registered stream.
// Define PKT_ARB_HDR_CHECK_EN to count header ID mismatches in hdr_err_cnt.
module axi_stream_pkt_arbiter #(
  parameter int NUM_IN = 4,
  parameter int ID_BASE = 0,
  localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic [64*NUM_IN-1:0]   in_tdata,
  input  logic [NUM_IN-1:0]      in_tvalid,
  input  logic [NUM_IN-1:0]      in_tlast,
  output logic [NUM_IN-1:0]      in_tready,
  output logic [63:0]            out_tdata,
  output logic                   out_tlast,
  output logic                   out_tvalid,
  input  logic                   out_tready,
  output logic [SEL_W-1:0]       cur_sel,
  output logic                   busy,
  output logic [31:0]            pkt_cnt,
  output logic [15:0]            hdr_err_cnt
);
  typedef enum logic {ST_IDLE, ST_PASS} state_t;
  state_t state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d, last_q, last_d, idx, grant;
  logic [63:0] data_q, data_d;
  logic tlast_q, tlast_d, valid_q, valid_d;
  logic [31:0] pkt_q, pkt_d;
  logic [63:0] words [NUM_IN];
  logic take, cap, found;
  genvar g;
  for (g = 0; g < NUM_IN; g++) begin : g_word
    assign words[g] = in_tdata[64*g +: 64];
  end
  // Round-robin search starting just after the last granted input
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx = '0;
    for (int k = 1; k <= NUM_IN; k++) begin
      idx = SEL_W'((int'(last_q) + k) % NUM_IN);
      if (!found && in_tvalid[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end
  assign take = !valid_q || out_tready;
  assign cap = (state_q == ST_PASS) && in_tvalid[sel_q] && take;
  assign in_tready = (state_q == ST_PASS && take) ? NUM_IN'(1) << sel_q : '0;
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    last_d = last_q;
    pkt_d = pkt_q;
    data_d = (valid_q && out_tready) ? 64'h0 : data_q;
    tlast_d = (valid_q && out_tready) ? 1'b0 : tlast_q;
    valid_d = (valid_q && out_tready) ? 1'b0 : valid_q;
    if (state_q == ST_IDLE && ena && found) begin
      state_d = ST_PASS;
      sel_d = grant;
    end
    if (cap) begin
      data_d = words[sel_q];
      tlast_d = in_tlast[sel_q];
      valid_d = 1'b1;
    end
    if (cap && in_tlast[sel_q]) begin
      state_d = ST_IDLE;
      last_d = sel_q;
      pkt_d = pkt_q + 32'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q <= '0;
      last_q <= SEL_W'(NUM_IN - 1);
      pkt_q <= '0;
      data_q <= '0;
      tlast_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      last_q <= last_d;
      pkt_q <= pkt_d;
      data_q <= data_d;
      tlast_q <= tlast_d;
      valid_q <= valid_d;
    end
  end
  assign out_tdata = data_q;
  assign out_tlast = tlast_q;
  assign out_tvalid = valid_q;
  assign cur_sel = sel_q;
  assign busy = (state_q == ST_PASS);
  assign pkt_cnt = pkt_q;
`ifdef PKT_ARB_HDR_CHECK_EN
  logic first_q, first_d, hdr_bad;
  logic [15:0] err_q, err_d;
  // The first capture after a grant is the header word
  assign hdr_bad = cap && first_q && (words[sel_q][63:56] != 8'(ID_BASE + int'(sel_q)));
  assign first_d = (state_q == ST_IDLE) ? 1'b1 : (cap ? 1'b0 : first_q);
  assign err_d = (hdr_bad && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      first_q <= 1'b0;
      err_q <= '0;
    end else begin
      first_q <= first_d;
      err_q <= err_d;
    end
  end
  assign hdr_err_cnt = err_q;
`else
  assign hdr_err_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_axi_stream_pkt_arbiter.sv
// tb_axi_stream_pkt_arbiter: randomized packet traffic checked against a round-robin packet-order model.
module tb_axi_stream_pkt_arbiter;
  localparam int N = 4;
  logic clk = 1'b0, rst = 1'b1, ena = 1'b1;
  logic [64*N-1:0] in_tdata;
  logic [N-1:0] in_tvalid, in_tlast, in_tready;
  logic [63:0] out_tdata;
  logic out_tlast, out_tvalid, out_tready;
  logic [1:0] cur_sel;
  logic busy;
  logic [31:0] pkt_cnt;
  logic [15:0] hdr_err_cnt;

  axi_stream_pkt_arbiter #(.NUM_IN(N), .ID_BASE(0)) dut (
    .clk(clk), .rst(rst), .ena(ena), .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tlast(in_tlast),
    .in_tready(in_tready), .out_tdata(out_tdata), .out_tlast(out_tlast), .out_tvalid(out_tvalid),
    .out_tready(out_tready), .cur_sel(cur_sel), .busy(busy), .pkt_cnt(pkt_cnt), .hdr_err_cnt(hdr_err_cnt)
  );

  always #5 clk = ~clk;

  logic [64:0] src_q [N][$];
  logic [64:0] mdl_q [N][$];
  logic [64:0] exp_q [$];
  logic [64:0] got_q [$];
  int got_cyc [$];
  int cyc = 0, compared = 0, mismatched = 0, stall_err = 0, onehot_err = 0, mdl_last = N - 1;
  bit force_valid = 1'b0, bp_rand = 1'b0, gap_en = 1'b0, stalled = 1'b0;
  bit at_start [N];
  logic [64:0] held;
  logic [31:0] seq_n = '0;

  // Source/sink driver: drive at negedge, observe handshakes just before the next posedge
  initial begin
    for (int i = 0; i < N; i++) at_start[i] = 1'b1;
    in_tvalid = '0;
    in_tdata = '0;
    in_tlast = '0;
    out_tready = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      out_tready = bp_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int i = 0; i < N; i++) begin
        if (src_q[i].size() > 0) begin
          in_tdata[64*i +: 64] = src_q[i][0][63:0];
          in_tlast[i] = src_q[i][0][64];
          in_tvalid[i] = !(gap_en && !at_start[i] && $urandom_range(0, 3) == 0);
        end else begin
          in_tdata[64*i +: 64] = '0;
          in_tlast[i] = 1'b0;
          in_tvalid[i] = force_valid;
        end
      end
      #4;
      if (rst) stalled = 1'b0;
      else begin
        for (int i = 0; i < N; i++)
          if (in_tvalid[i] && in_tready[i] && src_q[i].size() > 0) begin
            at_start[i] = src_q[i][0][64];
            void'(src_q[i].pop_front());
          end
        if ($countones(in_tready) > 1) onehot_err++;
        if (stalled && !(out_tvalid && {out_tlast, out_tdata} == held)) stall_err++;
        stalled = out_tvalid && !out_tready;
        held = {out_tlast, out_tdata};
        if (out_tvalid && out_tready) begin
          got_q.push_back(held);
          got_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic push_pkt(input int i, input logic [7:0] id, input int n);
    logic [64:0] w;
    for (int k = 0; k < n; k++) begin
      w[63:0] = (k == 0) ? {id, 8'h00, seq_n, 16'(n)} : {$urandom, $urandom};
      w[64] = (k == n - 1);
      src_q[i].push_back(w);
      mdl_q[i].push_back(w);
    end
    seq_n++;
  endtask

  // Whole packets leave in round-robin order of the inputs holding pending packets
  task automatic model_drain();
    logic [64:0] w;
    bit found;
    for (int p = 0; p < 1000; p++) begin
      found = 1'b0;
      for (int k = 1; k <= N && !found; k++) begin
        int i;
        i = (mdl_last + k) % N;
        if (mdl_q[i].size() > 0) begin
          found = 1'b1;
          mdl_last = i;
          do begin
            w = mdl_q[i].pop_front();
            exp_q.push_back(w);
          end while (!w[64]);
        end
      end
      if (!found) break;
    end
  endtask

  task automatic wait_drain(output bit ok);
    bit empty;
    ok = 1'b0;
    for (int c = 0; c < 3000 && !ok; c++) begin
      @(posedge clk);
      #1;
      empty = 1'b1;
      for (int i = 0; i < N; i++) if (src_q[i].size() > 0) empty = 1'b0;
      ok = empty && !out_tvalid && !busy;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic int first_diff();
    if (got_q.size() != exp_q.size()) return -2;
    foreach (got_q[k]) if (got_q[k] !== exp_q[k]) return k;
    return -1;
  endfunction

  function automatic logic [23:0] src_ids();
    logic [23:0] ids;
    bit sop;
    ids = '0;
    sop = 1'b1;
    foreach (got_q[k]) begin
      if (sop) ids = {ids[19:0], got_q[k][59:56]};
      sop = got_q[k][64];
    end
    return ids;
  endfunction

  task automatic clear_logs();
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
    stall_err = 0;
    onehot_err = 0;
  endtask

  task automatic test_reset();
    force_valid = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    compared++; if (in_tready !== 4'b0) begin mismatched++; $display("FAIL reset_in_tready: got %b want 0000", in_tready); end
    compared++; if (out_tvalid !== 1'b0 || out_tlast !== 1'b0) begin mismatched++; $display("FAIL reset_out_ctl: got valid=%b last=%b want 0 0", out_tvalid, out_tlast); end
    compared++; if (out_tdata !== 64'h0) begin mismatched++; $display("FAIL reset_out_tdata: got %h want 0", out_tdata); end
    compared++; if (busy !== 1'b0 || cur_sel !== 2'd0) begin mismatched++; $display("FAIL reset_busy_sel: got busy=%b sel=%0d want 0 0", busy, cur_sel); end
    compared++; if (pkt_cnt !== 32'd0 || hdr_err_cnt !== 16'd0) begin mismatched++; $display("FAIL reset_counters: got pkt=%0d hdr=%0d want 0 0", pkt_cnt, hdr_err_cnt); end
    force_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mdl_last = N - 1;
  endtask

  task automatic test_single();
    int t0, d;
    bit ok;
    clear_logs();
    @(posedge clk);
    #1;
    t0 = cyc + 1;
    push_pkt(1, 8'h01, 3);
    model_drain();
    wait_drain(ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL single_drain: got timeout want drained"); end
    d = first_diff();
    compared++; if (d != -1) begin mismatched++; $display("FAIL single_stream: got diff at %0d (%0d words) want %0d words", d, got_q.size(), exp_q.size()); end
    compared++; if (got_q.size() != 3) begin mismatched++; $display("FAIL single_count: got %0d want 3", got_q.size()); end
    if (got_q.size() == 3) begin
      compared++; if (got_q[0][63:0] !== 64'h0100_0000_0000_0003) begin mismatched++; $display("FAIL single_hdr: got %h want 0100000000000003", got_q[0][63:0]); end
      compared++; if ({got_q[0][64], got_q[1][64], got_q[2][64]} !== 3'b001) begin mismatched++; $display("FAIL single_tlast: got %b%b%b want 001", got_q[0][64], got_q[1][64], got_q[2][64]); end
      compared++; if (got_cyc[0] - t0 != 2) begin mismatched++; $display("FAIL single_latency: got %0d want 2", got_cyc[0] - t0); end
    end
    compared++; if (pkt_cnt !== 32'd1) begin mismatched++; $display("FAIL single_pkt_cnt: got %0d want 1", pkt_cnt); end
  endtask

  task automatic rr_traffic(input string name);
    int d;
    bit ok;
    @(posedge clk);
    #1;
    for (int p = 0; p < 3; p++) begin
      push_pkt(0, 8'h00, 4);
      push_pkt(2, 8'h02, 4);
    end
    model_drain();
    wait_drain(ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL %s_drain: got timeout want drained", name); end
    d = first_diff();
    compared++; if (d != -1) begin mismatched++; $display("FAIL %s_stream: got diff at %0d (%0d words) want %0d words", name, d, got_q.size(), exp_q.size()); end
    compared++; if (src_ids() !== 24'h020202) begin mismatched++; $display("FAIL %s_order: got %h want 020202", name, src_ids()); end
    compared++; if (onehot_err != 0) begin mismatched++; $display("FAIL %s_onehot: got %0d want 0", name, onehot_err); end
  endtask

  task automatic test_round_robin();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mdl_last = N - 1;
    clear_logs();
    rr_traffic("rr");
    compared++; if (pkt_cnt !== 32'd6) begin mismatched++; $display("FAIL rr_pkt_cnt: got %0d want 6", pkt_cnt); end
  endtask

  task automatic test_backpressure();
    clear_logs();
    bp_rand = 1'b1;
    rr_traffic("bp");
    bp_rand = 1'b0;
    compared++; if (stall_err != 0) begin mismatched++; $display("FAIL bp_stable: got %0d violations want 0", stall_err); end
    compared++; if (pkt_cnt !== 32'd12) begin mismatched++; $display("FAIL bp_pkt_cnt: got %0d want 12", pkt_cnt); end
  endtask

  task automatic test_ena_drop();
    int d;
    logic [31:0] base;
    bit ok;
    clear_logs();
    base = pkt_cnt;
    @(posedge clk);
    #1;
    push_pkt(3, 8'h03, 6);
    model_drain();
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(posedge clk);
      #1;
      ok = got_q.size() >= 2;
    end
    compared++; if (!ok) begin mismatched++; $display("FAIL ena_start: got %0d words want >=2", got_q.size()); end
    ena = 1'b0;
    push_pkt(0, 8'h00, 4);
    repeat (30) @(posedge clk);
    #1;
    compared++; if (got_q.size() != 6) begin mismatched++; $display("FAIL ena_complete: got %0d words want 6", got_q.size()); end
    compared++; if (src_q[0].size() != 4 || busy !== 1'b0) begin mismatched++; $display("FAIL ena_hold: got %0d left busy=%b want 4 0", src_q[0].size(), busy); end
    model_drain();
    ena = 1'b1;
    wait_drain(ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL ena_drain: got timeout want drained"); end
    d = first_diff();
    compared++; if (d != -1) begin mismatched++; $display("FAIL ena_stream: got diff at %0d (%0d words) want %0d words", d, got_q.size(), exp_q.size()); end
    compared++; if (pkt_cnt - base !== 32'd2) begin mismatched++; $display("FAIL ena_pkt_cnt: got %0d want 2", pkt_cnt - base); end
  endtask

  task automatic test_hdr();
    int d;
    logic [15:0] e0, e1;
    bit ok;
    clear_logs();
    e0 = hdr_err_cnt;
    @(posedge clk);
    #1;
    push_pkt(2, 8'h05, 3);
    model_drain();
    wait_drain(ok);
    e1 = hdr_err_cnt;
`ifdef PKT_ARB_HDR_CHECK_EN
    compared++; if (e1 !== e0 + 16'd1) begin mismatched++; $display("FAIL hdr_bad_id: got %0d want %0d", e1, e0 + 16'd1); end
`else
    compared++; if (e1 !== 16'd0) begin mismatched++; $display("FAIL hdr_bad_id: got %0d want 0", e1); end
`endif
    push_pkt(2, 8'h02, 2);
    model_drain();
    wait_drain(ok);
    compared++; if (hdr_err_cnt !== e1) begin mismatched++; $display("FAIL hdr_good_id: got %0d want %0d", hdr_err_cnt, e1); end
    d = first_diff();
    compared++; if (d != -1 || !ok) begin mismatched++; $display("FAIL hdr_stream: got diff at %0d drained=%b want -1 1", d, ok); end
  endtask

  task automatic test_random();
    int d, np;
    logic [31:0] base;
    logic [15:0] e0;
    bit ok;
    for (int r = 0; r < 4; r++) begin
      clear_logs();
      base = pkt_cnt;
      e0 = hdr_err_cnt;
      np = 0;
      bp_rand = r[0];
      gap_en = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
        for (int p = $urandom_range(0, 3); p > 0; p--) begin
          push_pkt(i, 8'(i), $urandom_range(1, 6));
          np++;
        end
      model_drain();
      wait_drain(ok);
      d = first_diff();
      compared++; if (d != -1 || !ok) begin mismatched++; $display("FAIL rand%0d_stream: got diff at %0d drained=%b want -1 1", r, d, ok); end
      compared++; if (pkt_cnt - base !== 32'(np)) begin mismatched++; $display("FAIL rand%0d_pkt_cnt: got %0d want %0d", r, pkt_cnt - base, np); end
      compared++; if (stall_err != 0 || onehot_err != 0) begin mismatched++; $display("FAIL rand%0d_proto: got stall=%0d onehot=%0d want 0 0", r, stall_err, onehot_err); end
      compared++; if (hdr_err_cnt !== e0) begin mismatched++; $display("FAIL rand%0d_hdr: got %0d want %0d", r, hdr_err_cnt, e0); end
    end
    bp_rand = 1'b0;
    gap_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_ena_drop();
    test_hdr();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
